// File: rtl/vga_fb_arbiter.sv
// Framebuffer port arbiter: the VGA prefetch always wins, the writer gets the leftover
// cycles, and each framebuffer pixel is upscaled 2^SCALE_LOG2 times in both axes.
module vga_fb_arbiter #(
    parameter int FB_W       = 160,
    parameter int FB_H       = 120,
    parameter int SCALE_LOG2 = 2,
    parameter int ADDR_W     = 15,
    parameter int RGB_W      = 3
) (
    input  logic              clk,
    input  logic              rst_l,
    input  logic [8:0]        vga_row,
    input  logic [9:0]        vga_col,
    input  logic              vga_display,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [RGB_W-1:0]  wr_data,
    output logic              wr_ack,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [RGB_W-1:0]  ram_wdata,
    input  logic [RGB_W-1:0]  ram_rdata,
    output logic [RGB_W-1:0]  pix_rgb,
    output logic              underrun
);

    localparam logic [ADDR_W-1:0] FBW_A    = ADDR_W'(FB_W);
    localparam logic [ADDR_W-1:0] FBH_A    = ADDR_W'(FB_H);
    localparam logic [ADDR_W-1:0] ONE_A    = ADDR_W'(1);
    localparam logic [ADDR_W:0]   FB_SIZE  = (ADDR_W+1)'(FB_W * FB_H);
    localparam logic [9:0]        ROW_LAST = 10'((FB_H << SCALE_LOG2) - 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t             state;
    logic [RGB_W-1:0]   next_pix;
    logic [RGB_W-1:0]   cur_pix;
    logic [ADDR_W-1:0]  tag_addr;
    logic               tag_vld;
    logic [ADDR_W-1:0]  pend_addr;
    logic [ADDR_W-1:0]  disp_reg;

    logic [ADDR_W-1:0]  x_a;
    logic [ADDR_W-1:0]  y_a;
    logic [ADDR_W-1:0]  yn_a;
    logic [9:0]         row_nxt;
    logic [ADDR_W-1:0]  disp_addr;
    logic [ADDR_W-1:0]  target;
    logic               need_rd;
    logic               grant;
    logic               wr_fire;
    logic               load;

    // Beam position to framebuffer address, and the pixel to have ready next.
    always_comb begin
        x_a       = ADDR_W'(vga_col >> SCALE_LOG2);
        y_a       = ADDR_W'(vga_row >> SCALE_LOG2);
        disp_addr = y_a * FBW_A + x_a;
        row_nxt   = {1'b0, vga_row} + 10'd1;
        yn_a      = ({1'b0, vga_row} >= ROW_LAST) ? '0 : ADDR_W'(row_nxt >> SCALE_LOG2);
        if (vga_display) begin
            if (x_a + ONE_A == FBW_A)
                target = (y_a + ONE_A == FBH_A) ? '0 : (y_a + ONE_A) * FBW_A;
            else
                target = disp_addr + ONE_A;
        end else begin
            target = yn_a * FBW_A;
        end
    end

    always_comb begin
        need_rd = (state == IDLE) && (!tag_vld || tag_addr != target);
        grant   = !need_rd && wr_req;
        wr_fire = grant && ({1'b0, wr_addr} < FB_SIZE);
        load    = vga_display && (disp_addr != disp_reg);
    end

    // All outputs are held low while reset is asserted.
    always_comb begin
        wr_ack    = rst_l && grant;
        ram_en    = rst_l && (need_rd || wr_fire);
        ram_we    = rst_l && wr_fire;
        ram_addr  = '0;
        ram_wdata = '0;
        if (rst_l && need_rd) begin
            ram_addr = target;
        end else if (rst_l && wr_fire) begin
            ram_addr  = wr_addr;
            ram_wdata = wr_data;
        end
        pix_rgb = (rst_l && vga_display) ? (load ? next_pix : cur_pix) : '0;
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state     <= IDLE;
            next_pix  <= '0;
            cur_pix   <= '0;
            tag_addr  <= '0;
            tag_vld   <= 1'b0;
            pend_addr <= '0;
            disp_reg  <= '1;
            underrun  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (need_rd) begin
                        pend_addr <= target;
                        state     <= RD_WAIT;
                    end else if (wr_fire && tag_vld && wr_addr == tag_addr) begin
                        tag_vld <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    // A write landing on the in-flight address makes the captured data stale.
                    next_pix <= ram_rdata;
                    tag_addr <= pend_addr;
                    tag_vld  <= !(wr_fire && wr_addr == pend_addr);
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (load) begin
                cur_pix  <= next_pix;
                disp_reg <= disp_addr;
                if (!tag_vld || tag_addr != disp_addr)
                    underrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: behavioural RAM, beam stepped at clk/2,
// writer handshakes, coherence cases and the sticky underrun flag.
module tb_vga_fb_arbiter;

    localparam int FB_W    = 160;
    localparam int FB_H    = 120;
    localparam int ADDR_W  = 15;
    localparam int RGB_W   = 3;
    localparam int FB_SIZE = FB_W * FB_H;

    logic              clk = 1'b0;
    logic              rst_l;
    logic [8:0]        vga_row;
    logic [9:0]        vga_col;
    logic              vga_display;
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [RGB_W-1:0]  wr_data;
    logic              wr_ack;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [RGB_W-1:0]  ram_wdata;
    logic [RGB_W-1:0]  ram_rdata;
    logic [RGB_W-1:0]  pix_rgb;
    logic              underrun;

    logic [RGB_W-1:0]  ram    [0:(1<<ADDR_W)-1];
    logic [RGB_W-1:0]  shadow [0:FB_SIZE-1];

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    vga_fb_arbiter #(.FB_W(FB_W), .FB_H(FB_H), .SCALE_LOG2(2), .ADDR_W(ADDR_W), .RGB_W(RGB_W)) dut (
        .clk(clk), .rst_l(rst_l), .vga_row(vga_row), .vga_col(vga_col), .vga_display(vga_display),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .pix_rgb(pix_rgb), .underrun(underrun)
    );

    // Single-port synchronous RAM, read data one cycle after the read.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) ram[ram_addr] = ram_wdata;
            else        ram_rdata <= ram[ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One screen pixel = two clocks; called and returns at a falling edge.
    task automatic pix_step(input int row, input int col, input bit disp, input bit chk);
        vga_row     = 9'(row);
        vga_col     = 10'(col);
        vga_display = disp;
        @(negedge clk);
        if (chk)
            check($sformatf("pix r%0d c%0d", row, col), 32'(pix_rgb),
                  32'(shadow[(row >> 2) * FB_W + (col >> 2)]));
        @(negedge clk);
    endtask

    task automatic scan_row(input int row, input bit chk);
        int rp;
        rp = (row == 0) ? 500 : row - 1;
        for (int c = 640; c < 660; c++) pix_step(rp, c, 1'b0, 1'b0);
        for (int c = 0; c < 640; c++) pix_step(row, c, 1'b1, chk);
    endtask

    // Called at a falling edge; returns at a falling edge after the acked cycle.
    task automatic do_write(input int addr, input int data, output int waited,
                            output bit acked, output bit en_at_ack);
        wr_req  = 1'b1;
        wr_addr = ADDR_W'(addr);
        wr_data = RGB_W'(data);
        waited  = 0;
        #1;
        while (!wr_ack && waited < 6) begin
            @(negedge clk);
            #1;
            waited++;
        end
        acked     = wr_ack;
        en_at_ack = ram_en;
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int w;
        bit a;
        bit e;
        int max_w;
        int nack;
        int bad;

        for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = RGB_W'(i % 8);
        for (int i = 0; i < FB_SIZE; i++) shadow[i] = RGB_W'(i % 8);
        ram_rdata   = '0;
        rst_l       = 1'b0;
        vga_row     = 9'd0;
        vga_col     = 10'd0;
        vga_display = 1'b1;
        wr_req      = 1'b1;
        wr_addr     = ADDR_W'(5);
        wr_data     = 3'd3;
        repeat (3) @(negedge clk);
        #1;
        check("rst pix_rgb", 32'(pix_rgb), 0);
        check("rst wr_ack", 32'(wr_ack), 0);
        check("rst ram_en", 32'(ram_en), 0);
        check("rst ram_we", 32'(ram_we), 0);
        check("rst ram_addr", 32'(ram_addr), 0);
        check("rst underrun", 32'(underrun), 0);

        wr_req      = 1'b0;
        vga_display = 1'b0;
        vga_row     = 9'd500;
        @(negedge clk);
        rst_l = 1'b1;
        #1;
        check("post-rst read en", 32'(ram_en), 1);
        check("post-rst read we", 32'(ram_we), 0);
        check("post-rst read addr", 32'(ram_addr), 0);
        check("post-rst wr_ack", 32'(wr_ack), 0);
        @(negedge clk);

        // Preloaded image i mod 8 across the first eight lines.
        for (int r = 0; r < 8; r++) scan_row(r, 1'b1);
        check("underrun after rows 0-7", 32'(underrun), 0);

        // Write to the tagged (prefetched) pixel while the beam sits in fb col 4.
        for (int c = 640; c < 660; c++) pix_step(3, c, 1'b0, 1'b0);
        for (int c = 0; c < 17; c++) pix_step(4, c, 1'b1, 1'b1);
        shadow[165] = 3'd7;
        fork
            pix_step(4, 17, 1'b1, 1'b1);
            do_write(165, 7, w, a, e);
        join
        check("tag write wait", w, 0);
        check("tag write ack", 32'(a), 1);
        for (int c = 18; c < 24; c++) pix_step(4, c, 1'b1, 1'b1);
        check("tag write ram", 32'(ram[165]), 7);

        // Write to the in-flight read address during RD_WAIT.
        shadow[167] = 3'd5;
        fork
            pix_step(4, 24, 1'b1, 1'b1);
            do_write(167, 5, w, a, e);
        join
        check("pend write wait", w, 1);
        check("pend reread en", 32'(ram_en), 1);
        check("pend reread we", 32'(ram_we), 0);
        check("pend reread addr", 32'(ram_addr), 167);
        for (int c = 25; c < 640; c++) pix_step(4, c, 1'b1, 1'b1);

        // Out-of-range write is acked but dropped.
        for (int c = 640; c < 660; c++) pix_step(4, c, 1'b0, 1'b0);
        do_write(FB_SIZE, 5, w, a, e);
        check("oob ack", 32'(a), 1);
        check("oob ram_en", 32'(e), 0);
        check("oob ram unchanged", 32'(ram[FB_SIZE]), 0);

        // Random writer traffic during scanout.
        max_w = 0;
        nack  = 0;
        fork
            begin
                scan_row(9, 1'b0);
                scan_row(10, 1'b0);
            end
            begin
                for (int k = 0; k < 40; k++) begin
                    int addr;
                    int data;
                    int wk;
                    bit ak;
                    bit ek;
                    repeat ($urandom_range(0, 12)) @(negedge clk);
                    addr = int'($urandom_range(0, FB_SIZE - 1));
                    data = int'($urandom_range(0, 7));
                    do_write(addr, data, wk, ak, ek);
                    shadow[addr] = RGB_W'(data);
                    if (wk > max_w) max_w = wk;
                    if (!ak) nack++;
                end
            end
        join
        check("random write max wait<=2", 32'(max_w <= 2), 1);
        check("random write unacked", nack, 0);
        bad = 0;
        for (int i = 0; i < FB_SIZE; i++) if (ram[i] !== shadow[i]) bad++;
        check("ram vs write log", bad, 0);
        check("underrun after writer traffic", 32'(underrun), 0);
        scan_row(11, 1'b1);
        check("underrun after row 11", 32'(underrun), 0);

        // Beam jump from col 8 to col 40 misses the prefetch.
        for (int c = 640; c < 660; c++) pix_step(11, c, 1'b0, 1'b0);
        for (int c = 0; c < 9; c++) pix_step(12, c, 1'b1, 1'b1);
        pix_step(12, 40, 1'b1, 1'b0);
        check("underrun set", 32'(underrun), 1);
        for (int c = 41; c < 60; c++) pix_step(12, c, 1'b1, 1'b0);
        check("underrun sticky", 32'(underrun), 1);

        wr_req  = 1'b1;
        wr_addr = ADDR_W'(10);
        wr_data = 3'd6;
        rst_l   = 1'b0;
        #1;
        check("final rst underrun", 32'(underrun), 0);
        check("final rst pix_rgb", 32'(pix_rgb), 0);
        check("final rst wr_ack", 32'(wr_ack), 0);
        check("final rst ram_en", 32'(ram_en), 0);
        check("final rst ram_we", 32'(ram_we), 0);
        check("final rst ram_wdata", 32'(ram_wdata), 0);
        wr_req = 1'b0;
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port synchronous framebuffer RAM (FB_W x FB_H, RGB_W bits/pixel) between two requesters:
  - VGA scanout: hard deadline, always wins.
  - A drawing/CPU writer using a req/ack handshake.
- Prefetches the next framebuffer pixel ahead of the beam from vga_driver's row/col/display outputs.
- Drives the pixel colour for the VGA pins, with each framebuffer pixel upscaled by 2^SCALE_LOG2 in both axes.

Parameters:
- FB_W, 160, framebuffer width in pixels.
- FB_H, 120, framebuffer height in pixels.
- SCALE_LOG2, 2, log2 of screen pixels per framebuffer pixel, per axis.
- ADDR_W, 15, RAM address width; must satisfy 2^ADDR_W >= FB_W*FB_H.
- RGB_W, 3, bits per pixel.

Ports:
- clk  in  1  system clock.
- rst_l  in  1  asynchronous active-low reset.
- vga_row  in  9  current display row from vga_driver.
- vga_col  in  10  current display column from vga_driver.
- vga_display  in  1  high inside the visible region.
- wr_req  in  1  writer request; held high until acked.
- wr_addr  in  ADDR_W  write address, y*FB_W+x.
- wr_data  in  RGB_W  write pixel.
- wr_ack  out  1  one-cycle pulse; write performed (or dropped) this cycle.
- ram_en  out  1  RAM enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  ADDR_W  RAM address.
- ram_wdata  out  RGB_W  RAM write data.
- ram_rdata  in  RGB_W  RAM read data, valid one cycle after a read.
- pix_rgb  out  RGB_W  colour to the VGA pins.
- underrun  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Clock and reset interface (decided): single clock clk; reset rst_l is asynchronous, active-low.
- Reset values:
  - State IDLE; next_pix, cur_pix = 0; tag invalid; disp_addr register = all-ones.
  - wr_ack, ram_en, ram_we, underrun = 0; pix_rgb = 0.
- Screen-to-framebuffer mapping: x = vga_col>>SCALE_LOG2, y = vga_row>>SCALE_LOG2, disp_addr = y*FB_W+x.
  - Address arithmetic is done at ADDR_W width.
- Fetch target:
  - When vga_display=1: the framebuffer pixel after (x,y).
  - If x+1 = FB_W, the target is (0, y+1).
  - If y+1 = FB_H, the target is (0, 0).
  - When vga_display=0: target is (0, yn), where yn = (vga_row+1)>>SCALE_LOG2, forced to 0 if vga_row >= FB_H<<SCALE_LOG2 - 1.
- Tag register: holds the address next_pix belongs to, plus a valid bit.
- FSM states:
  - IDLE: if tag is invalid or tag != target, issue a read: ram_en=1, ram_we=0, ram_addr=target. Record pend_addr and go to RD_WAIT. Otherwise the port is free.
  - RD_WAIT: capture ram_rdata into next_pix, set tag = pend_addr valid, go to IDLE. The port is free in this cycle.
- Writer grant:
  - Granted in any cycle where the port is free.
  - On grant: ram_en=1, ram_we=1, ram_addr=wr_addr, ram_wdata=wr_data, wr_ack=1, all combinational in the same cycle.
  - Display read beats writer whenever both want the port.
  - wr_addr >= FB_W*FB_H: wr_ack=1 but ram_en=0 (write dropped).
- Coherence:
  - A granted write whose address equals the valid tag invalidates the tag.
  - A granted write in RD_WAIT whose address equals pend_addr leaves the tag invalid after capture.
  - Either case forces a refetch.
- Display load:
  - When vga_display=1 and disp_addr != the disp_addr register: cur_pix <= next_pix and the register updates.
  - If at that edge the tag is invalid or != disp_addr, set underrun.
- pix_rgb (combinational):
  - vga_display=0: 0.
  - Otherwise: next_pix in a load cycle, else cur_pix.
- Bandwidth guarantee:
  - With pixel rate <= clk/2, a new framebuffer pixel is needed every >= 8 clks.
  - The display uses <= 2 of every 8 cycles, so writer wait <= 2 cycles and underrun never fires in normal operation.
- rst_l asserted mid-read or mid-write: the op is abandoned and a write may be lost. No ack is issued after reset.

Test Plan:
- Reset, then run the frame with the RAM preloaded pixel i = i mod 8 -> screen col 0..3 of row 0 shows 0, cols 4..7 show 1, line 1 same as line 0; underrun stays 0 for a full frame.
- wr_req held continuously with random addr/data during scanout -> every request acked within 3 cycles; no read deferred; underrun 0; final RAM contents match the write log.
- Write to the address equal to the valid tag (e.g. pixel (5,0) while beam is in fb col 4) -> tag invalidated, refetch issued, new colour displayed at fb col 5.
- Write to pend_addr during RD_WAIT -> following IDLE cycle reissues the read; displayed value equals the written data.
- wr_addr = 19200 -> wr_ack pulses, ram_en=0 that cycle, RAM unchanged.
- Force tag mismatch by holding wr priority via a testbench override (or a vga_col jump from 8 to 40) -> underrun rises and stays 1 until rst_l low, after which all outputs are 0.
